seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Output-side counterpart to the board's push-button input conditioning: drives a multiplexed, common-anode seven-segment display from a CPU-written hex value.
- Holds a tear-free display register that updates only at frame boundaries.
- Time-multiplexes the digits, with an anti-ghosting blank gap at the start of each digit slot.
- Sits on the board I/O peripheral next to the LED/switch logic.

Parameters:
- C_DIGITS, 8, number of digits driven (valid range 2..8).
- C_SCAN_BITS, 16, prescaler width; each digit slot lasts 2^C_SCAN_BITS cycles.
- C_GAP_CYCLES, 64, cycles at the start of each slot with all anodes off; must be less than 2^C_SCAN_BITS.

Ports:
- CLK  input  1  clock.
- RESETN  input  1  reset. Synchronous, active-low; clock CLK.
- WR_EN  input  1  write strobe, single-cycle qualifier.
- WR_DATA  input  4*C_DIGITS  hex nibbles; digit i is WR_DATA[4i+3:4i].
- WR_MASK  input  C_DIGITS  per-digit enable (1 = shown).
- PENDING  output  1  high while a write is accepted but not yet committed to the display.
- AN  output  C_DIGITS  anodes, active-low; AN[i] selects digit i.
- SEG  output  7  segments, active-low, ordered {g,f,e,d,c,b,a}.

Behaviour:
- Reset (RESETN=0 at a CLK edge):
  - AN = all ones, SEG = 7'h7F, PENDING = 0.
  - Prescaler, digit index, display data, display mask and pending registers are cleared to 0.
  - A reset mid-frame discards any uncommitted write.
- Prescaler (C_SCAN_BITS wide) increments every cycle and wraps from all-ones to 0.
  - On the wrap cycle, the digit index advances.
  - The index wraps from C_DIGITS-1 to 0.
- Frame boundary = cycle where prescaler is all-ones and index is C_DIGITS-1.
- Write:
  - WR_EN=1 captures WR_DATA and WR_MASK into the pending registers and sets PENDING on the next edge.
  - Back-to-back writes: the last one wins.
  - WR_EN on a non-boundary cycle: data is committed at the next frame boundary.
  - Commit copies pending into the display registers and clears PENDING in the same edge.
  - WR_EN on the boundary cycle itself: WR_DATA/WR_MASK load directly into the display registers; PENDING stays/becomes 0.
- Digit drive (computed from the current prescaler/index, registered; latency 1 cycle):
  - If prescaler < C_GAP_CYCLES, or the display mask bit for the index is 0: AN = all ones, SEG = 7'h7F.
  - Otherwise: AN = ~(1 << index), SEG = decode(display nibble[index]).
- Decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- At most one AN bit is ever low. AN must never glitch low during the gap, including across index changes.

Optional Feature:
- Macro: SEG7_LZB_EN (leading-zero blanking).
- Defined:
  - Digits above the most significant nonzero nibble of the display data are treated as masked.
  - Digit 0 is always shown if its mask bit is 1.
  - Blanking is evaluated on the committed display data, not on pending data.
- Undefined: every digit whose mask bit is 1 is shown, including leading zeros.

Test Plan (C_DIGITS=4, C_SCAN_BITS=3, C_GAP_CYCLES=2 unless noted):
- Reset: hold RESETN=0 for 3 cycles, then release -> AN=4'b1111, SEG=7'h7F, PENDING=0. After release, the first non-gap slot shows digit 0 as '0' only once a write unmasks it; before that AN stays 4'b1111.
- Write 16'h12AF with mask 4'b1111 mid-frame -> PENDING=1 until the frame boundary, then 0.
  - The next frame shows slot0 AN=1110 SEG=0001110 (F), slot1 AN=1101 SEG=0001000 (A), slot2 AN=1011 SEG=0100100 (2), slot3 AN=0111 SEG=1111001 (1).
  - In each slot, the first 2 cycles have AN=1111.
- Two writes in one frame (16'h1111 then 16'h2222) -> only 2222 is displayed; 1111 never appears.
- WR_EN exactly on the boundary cycle with 16'h3333 -> digit 0 of the very next slot shows 3 (SEG=0110000); PENDING never asserts.
- Mask 4'b0101 with data 16'h8888 -> slots 1 and 3 keep AN=1111 for the whole slot; slots 0 and 2 show 8 (SEG=0000000).
- With SEG7_LZB_EN: data 16'h0050, mask 4'b1111 -> digits 3 and 2 blanked, digit 1 shows 5, digit 0 shows 0. Without the macro, all four digits are shown.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver_if
// Write bus into the seven-segment scan driver.
//   WR_EN    : single-cycle write strobe (master -> slave)
//   WR_DATA  : hex nibbles, digit i in WR_DATA[4i+3:4i] (master -> slave)
//   WR_MASK  : per-digit enable, 1 = digit shown (master -> slave)
//   PENDING  : a write is held but not yet on the display (slave -> master)
// ---------------------------------------------------------------------------
interface seg7_scan_driver_if #(
  parameter int C_DIGITS = 8
);
  logic                    WR_EN;
  logic [4*C_DIGITS-1:0]   WR_DATA;
  logic [C_DIGITS-1:0]     WR_MASK;
  logic                    PENDING;

  modport master (output WR_EN, output WR_DATA, output WR_MASK, input PENDING);
  modport slave  (input WR_EN, input WR_DATA, input WR_MASK, output PENDING);
endinterface

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
// Multiplexed common-anode seven-segment driver. A CPU write is held in a
// pending register and copied to the display register only at a frame
// boundary, so a frame never shows a mix of old and new digits. Each digit
// slot starts with an all-anodes-off gap to stop ghosting.
//
// Ports:
//   CLK     : clock
//   RESETN  : synchronous, active-low reset
//   wr      : write bus (WR_EN, WR_DATA, WR_MASK in; PENDING out)
//   AN      : anodes, active-low, AN[i] selects digit i
//   SEG     : segments, active-low, {g,f,e,d,c,b,a}
//
// Optional feature: define SEG7_LZB_EN for leading-zero blanking, evaluated
// on the committed display data. Digit 0 is never blanked by it.
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int C_DIGITS     = 8,
  parameter int C_SCAN_BITS  = 16,
  parameter int C_GAP_CYCLES = 64
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  seg7_scan_driver_if.slave    wr,
  output logic [C_DIGITS-1:0]  AN,
  output logic [6:0]           SEG
);

  localparam int IDX_W = (C_DIGITS > 1) ? $clog2(C_DIGITS) : 1;
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(C_DIGITS - 1);
  localparam logic [C_SCAN_BITS-1:0] GAP_END  = C_SCAN_BITS'(C_GAP_CYCLES);

  logic [C_SCAN_BITS-1:0] prescaler;
  logic [IDX_W-1:0]       idx;
  logic [4*C_DIGITS-1:0]  disp_data;
  logic [C_DIGITS-1:0]    disp_mask;
  logic [4*C_DIGITS-1:0]  pend_data;
  logic [C_DIGITS-1:0]    pend_mask;
  logic                   pending;

  logic                   slot_end;
  logic                   frame_end;
  logic [C_DIGITS-1:0]    show_mask;
  logic [3:0]             cur_nib;
  logic                   cur_show;

  assign slot_end   = &prescaler;
  assign frame_end  = slot_end && (idx == LAST_IDX);
  assign wr.PENDING = pending;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  // Scan timing: the prescaler free-runs and the digit index steps on each
  // prescaler wrap, returning to 0 after the last digit.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      prescaler <= '0;
      idx       <= '0;
    end else begin
      prescaler <= prescaler + C_SCAN_BITS'(1);
      if (slot_end)
        idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    end
  end

  // Write path: writes off the boundary park in the pending registers (last
  // one wins); at the boundary either a same-cycle write goes straight to the
  // display or a parked write is committed. Both clear PENDING.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      disp_data <= '0;
      disp_mask <= '0;
      pend_data <= '0;
      pend_mask <= '0;
      pending   <= 1'b0;
    end else if (frame_end) begin
      if (wr.WR_EN) begin
        disp_data <= wr.WR_DATA;
        disp_mask <= wr.WR_MASK;
      end else if (pending) begin
        disp_data <= pend_data;
        disp_mask <= pend_mask;
      end
      pending <= 1'b0;
    end else if (wr.WR_EN) begin
      pend_data <= wr.WR_DATA;
      pend_mask <= wr.WR_MASK;
      pending   <= 1'b1;
    end
  end

  // Effective digit mask. With blanking enabled, digits above the most
  // significant nonzero nibble are suppressed; digit 0 keeps its own mask.
`ifdef SEG7_LZB_EN
  logic [IDX_W-1:0] top_idx;
  always_comb begin
    top_idx = '0;
    for (int i = 1; i < C_DIGITS; i++)
      if (disp_data[4*i +: 4] != 4'h0)
        top_idx = IDX_W'(i);
    show_mask = disp_mask;
    for (int i = 1; i < C_DIGITS; i++)
      if (IDX_W'(i) > top_idx)
        show_mask[i] = 1'b0;
  end
`else
  always_comb begin
    show_mask = disp_mask;
  end
`endif

  // Select the nibble and visibility of the digit currently being scanned.
  always_comb begin
    cur_nib  = 4'h0;
    cur_show = 1'b0;
    for (int i = 0; i < C_DIGITS; i++)
      if (idx == IDX_W'(i)) begin
        cur_nib  = disp_data[4*i +: 4];
        cur_show = show_mask[i];
      end
  end

  // Registered drive. Because AN comes straight from a flop fed by the scan
  // state, it cannot glitch low while the gap is active.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      AN  <= '1;
      SEG <= 7'h7F;
    end else if ((prescaler < GAP_END) || !cur_show) begin
      AN  <= '1;
      SEG <= 7'h7F;
    end else begin
      AN  <= ~(C_DIGITS'(1) << idx);
      SEG <= hex_to_seg(cur_nib);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
// Scoreboard bench for seg7_scan_driver (4 digits, 8-cycle slots, 2-cycle
// gap). The stimulus side drives one cycle at a time, predicts the outputs
// after the coming edge from a cycle-count model of the scan and pushes them
// into a queue; a monitor pops and compares after every edge.
// Honours SEG7_LZB_EN in its model when the macro is defined.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int SB    = 3;
  localparam int GAP   = 2;
  localparam int SLOT  = 1 << SB;
  localparam int FRAME = SLOT * ND;

  logic          CLK = 1'b0;
  logic          RESETN;
  logic [ND-1:0] AN;
  logic [6:0]    SEG;

  seg7_scan_driver_if #(.C_DIGITS(ND)) wr_bus ();

  seg7_scan_driver #(
    .C_DIGITS    (ND),
    .C_SCAN_BITS (SB),
    .C_GAP_CYCLES(GAP)
  ) dut (
    .CLK   (CLK),
    .RESETN(RESETN),
    .wr    (wr_bus),
    .AN    (AN),
    .SEG   (SEG)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          pend;
  } exp_t;

  exp_t exp_q[$];

  int n_compared   = 0;
  int n_mismatched = 0;

  // Segment patterns for hex digits 0..F, active-low {g..a}
  logic [6:0] seg_lut [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model: time since reset release plus committed / parked write
  int           m_n = 0;
  logic [15:0]  m_disp = '0;
  logic [3:0]   m_mask = '0;
  logic [15:0]  m_pdata = '0;
  logic [3:0]   m_pmask = '0;
  logic         m_pend = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // One clock cycle of stimulus: drive inputs, predict post-edge outputs,
  // advance the model, then wait for the next falling edge.
  task automatic applyStimulus(input logic rst_n, input logic en,
                               input logic [15:0] data, input logic [3:0] mask);
    exp_t e;
    int   pre, slot, top;
    bit   shown, boundary;
    RESETN          = rst_n;
    wr_bus.WR_EN    = en;
    wr_bus.WR_DATA  = data;
    wr_bus.WR_MASK  = mask;
    if (!rst_n) begin
      e.an = '1; e.seg = 7'h7F; e.pend = 1'b0;
      m_n = 0; m_disp = '0; m_mask = '0; m_pdata = '0; m_pmask = '0; m_pend = 1'b0;
    end else begin
      pre      = m_n % SLOT;
      slot     = (m_n / SLOT) % ND;
      boundary = ((m_n % FRAME) == FRAME - 1);
      shown    = m_mask[slot] && (pre >= GAP);
`ifdef SEG7_LZB_EN
      top = 0;
      for (int i = 0; i < ND; i++)
        if (m_disp[4*i +: 4] != 4'h0) top = i;
      if (slot > top) shown = 1'b0;
`else
      top = ND - 1;
`endif
      if (shown) begin
        e.an  = ~(ND'(1) << slot);
        e.seg = seg_lut[m_disp[4*slot +: 4]];
      end else begin
        e.an  = '1;
        e.seg = 7'h7F;
      end
      if (boundary) begin
        if (en) begin
          m_disp = data; m_mask = mask;
        end else if (m_pend) begin
          m_disp = m_pdata; m_mask = m_pmask;
        end
        m_pend = 1'b0;
      end else if (en) begin
        m_pdata = data; m_pmask = mask; m_pend = 1'b1;
      end
      e.pend = m_pend;
      m_n++;
    end
    exp_q.push_back(e);
    @(negedge CLK);
  endtask

  task automatic idleCycles(input int count);
    for (int i = 0; i < count; i++)
      applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
  endtask

  // Idle until the model's next cycle sits at the given frame phase
  task automatic idleUntil(input int phase);
    while ((m_n % FRAME) != phase)
      applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
  endtask

  // Monitor: compare every post-edge output against the queued prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("AN", 32'(AN), 32'(e.an));
        checkOutput("SEG", 32'(SEG), 32'(e.seg));
        checkOutput("PENDING", 32'(wr_bus.PENDING), 32'(e.pend));
        checkOutput("AN_one_cold", 32'($countones(~AN) <= 1), 32'd1);
      end
    end
  end

  initial begin
    logic        rst_n, en;
    logic [15:0] data;
    logic [3:0]  mask;

    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 16'h0, 4'h0);
    idleCycles(40);

    // mid-frame write, shown from the next frame
    idleUntil(3);
    applyStimulus(1'b1, 1'b1, 16'h12AF, 4'hF);
    idleCycles(2 * FRAME);

    // two writes in one frame, last one wins
    idleUntil(5);
    applyStimulus(1'b1, 1'b1, 16'h1111, 4'hF);
    idleUntil(10);
    applyStimulus(1'b1, 1'b1, 16'h2222, 4'hF);
    idleCycles(FRAME + 8);

    // write exactly on the frame boundary
    idleUntil(FRAME - 1);
    applyStimulus(1'b1, 1'b1, 16'h3333, 4'hF);
    idleCycles(FRAME + 4);

    // partial mask
    idleUntil(12);
    applyStimulus(1'b1, 1'b1, 16'h8888, 4'b0101);
    idleCycles(2 * FRAME);

    // leading zeros
    idleUntil(20);
    applyStimulus(1'b1, 1'b1, 16'h0050, 4'hF);
    idleCycles(2 * FRAME);

    // randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      en    = ($urandom_range(0, 9) == 0);
      data  = 16'($urandom);
      mask  = 4'($urandom);
      applyStimulus(rst_n, en, data, mask);
    end
    idleCycles(2);

    @(posedge CLK);
    #3;
    checkOutput("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
